// File: rtl/dmem_arbiter.sv
// Purpose : shares one single-port Datamemory between the core load/store path (port 0) and debug/DMA (port 1).
// Latency : grant is combinational in the request cycle; the response is registered and arrives one cycle later.
// Backpr. : port 0 wins by default; a waiting port-1 request is forced through after MAX_WAIT lost cycles.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready              request handshake (accepted on a rising edge with valid && ready)
//   reqN_we/addr/wdata/strb       request payload, held stable by the requester until ready
//   rspN_valid/rdata              one-cycle response pulse; rdata is read data or 0 for writes
//   mem_*                         drive/return of the attached Datamemory (combinational read port)
module dmem_arbiter #(
   parameter int DEPTH    = 128,
   parameter int MAX_WAIT = 4,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [31:0]   req0_wdata,
   input  logic [2:0]    req0_strb,
   output logic          rsp0_valid,
   output logic [31:0]   rsp0_rdata,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [31:0]   req1_wdata,
   input  logic [2:0]    req1_strb,
   output logic          rsp1_valid,
   output logic [31:0]   rsp1_rdata,
   output logic          mem_we0,
   output logic [AW-1:0] mem_rd_addr0,
   input  logic [31:0]   mem_rd_dout0,
   output logic [AW-1:0] mem_wr_addr0,
   output logic [31:0]   mem_wr_din0,
   output logic [2:0]    mem_wr_strb
);

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic        grant0;
   logic        grant1;
   logic [7:0]  wait_cnt_d,   wait_cnt_q;
   logic        rsp0_valid_d, rsp0_valid_q;
   logic        rsp1_valid_d, rsp1_valid_q;
   logic [31:0] rsp0_rdata_d, rsp0_rdata_q;
   logic [31:0] rsp1_rdata_d, rsp1_rdata_q;

   // Grants are suppressed while rst is high so no memory write can slip through.
   always_comb begin
      grant1 = ~rst & req1_valid & (~req0_valid | (wait_cnt_q == WAIT_MAX));
      grant0 = ~rst & req0_valid & ~grant1;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Memory drive: the granted port's request, all zeros when idle.
   always_comb begin
      mem_we0      = 1'b0;
      mem_rd_addr0 = '0;
      mem_wr_addr0 = '0;
      mem_wr_din0  = '0;
      mem_wr_strb  = '0;
      if (grant1) begin
         mem_we0      = req1_we;
         mem_rd_addr0 = req1_addr;
         mem_wr_addr0 = req1_addr;
         mem_wr_din0  = req1_wdata;
         mem_wr_strb  = req1_strb;
      end else if (grant0) begin
         mem_we0      = req0_we;
         mem_rd_addr0 = req0_addr;
         mem_wr_addr0 = req0_addr;
         mem_wr_din0  = req0_wdata;
         mem_wr_strb  = req0_strb;
      end
   end

   // Counts consecutive cycles a port-1 request has lost; reaching WAIT_MAX forces its grant.
   always_comb begin
      wait_cnt_d = '0;
      if (req1_valid && !grant1) begin
         wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 8'd1;
      end
   end

   // Response capture: read data comes from the combinational memory port in the grant cycle.
   // The idle port keeps its last rdata.
   always_comb begin
      rsp0_valid_d = grant0;
      rsp1_valid_d = grant1;
      rsp0_rdata_d = rsp0_rdata_q;
      rsp1_rdata_d = rsp1_rdata_q;
      if (grant0) begin
         rsp0_rdata_d = req0_we ? 32'd0 : mem_rd_dout0;
      end
      if (grant1) begin
         rsp1_rdata_d = req1_we ? 32'd0 : mem_rd_dout0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q   <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : bench for dmem_arbiter (DEPTH=8, MAX_WAIT=4) with an attached word memory and a reference model.
// Latency : model predicts combinational grants/memory drive and one-cycle registered responses.
// Backpr. : randomized requesters hold valid and payload until their ready is seen.
module tb_dmem_arbiter;

   localparam int DEPTH    = 8;
   localparam int MAX_WAIT = 4;
   localparam int AW       = 3;

   logic          clk;
   logic          rst;
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [31:0]   req0_wdata;
   logic [2:0]    req0_strb;
   logic          rsp0_valid;
   logic [31:0]   rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [31:0]   req1_wdata;
   logic [2:0]    req1_strb;
   logic          rsp1_valid;
   logic [31:0]   rsp1_rdata;
   logic          mem_we0;
   logic [AW-1:0] mem_rd_addr0, mem_wr_addr0;
   logic [31:0]   mem_rd_dout0, mem_wr_din0;
   logic [2:0]    mem_wr_strb;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_we0(mem_we0), .mem_rd_addr0(mem_rd_addr0), .mem_rd_dout0(mem_rd_dout0),
      .mem_wr_addr0(mem_wr_addr0), .mem_wr_din0(mem_wr_din0), .mem_wr_strb(mem_wr_strb)
   );

   always #5 clk = ~clk;

   // Attached Datamemory: combinational read, write on the rising edge.
   logic [31:0] dmem [DEPTH];
   assign mem_rd_dout0 = dmem[mem_rd_addr0];
   always @(posedge clk) begin
      if (mem_we0) dmem[mem_wr_addr0] <= mem_wr_din0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [DEPTH];
   bit          model_on = 0;
   int          m_lost   = 0;   // consecutive lost cycles of the pending port-1 request
   bit          m_rv0 = 0, m_rv1 = 0;
   logic [31:0] m_rd0 = 0, m_rd1 = 0;

   always @(negedge clk) begin
      if (model_on) begin
         if (rst) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_mem_we", mem_we0, 0);
            check("rst_rsp0_v", rsp0_valid, 0);
            check("rst_rsp1_v", rsp1_valid, 0);
            check("rst_rsp0_d", rsp0_rdata, 0);
            check("rst_rsp1_d", rsp1_rdata, 0);
            check("rst_wait", dut.wait_cnt_q, 0);
            m_lost = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
         end else begin
            int winner;
            logic          e_we;
            logic [AW-1:0] e_addr;
            logic [31:0]   e_din;
            logic [2:0]    e_strb;
            // Port 1 gets through when uncontested or after MAX_WAIT lost cycles.
            if (req1_valid && (!req0_valid || m_lost == MAX_WAIT)) winner = 1;
            else if (req0_valid) winner = 0;
            else winner = -1;
            e_we = 0; e_addr = 0; e_din = 0; e_strb = 0;
            if (winner == 0) begin e_we = req0_we; e_addr = req0_addr; e_din = req0_wdata; e_strb = req0_strb; end
            if (winner == 1) begin e_we = req1_we; e_addr = req1_addr; e_din = req1_wdata; e_strb = req1_strb; end
            check("ready0", req0_ready, winner == 0);
            check("ready1", req1_ready, winner == 1);
            check("mem_we", mem_we0, e_we);
            check("mem_rd_addr", mem_rd_addr0, e_addr);
            check("mem_wr_addr", mem_wr_addr0, e_addr);
            check("mem_din", mem_wr_din0, e_din);
            check("mem_strb", mem_wr_strb, e_strb);
            check("rsp0_v", rsp0_valid, m_rv0);
            check("rsp1_v", rsp1_valid, m_rv1);
            check("rsp0_d", rsp0_rdata, m_rd0);
            check("rsp1_d", rsp1_rdata, m_rd1);
            check("wait_cnt", dut.wait_cnt_q, m_lost);
            // state after the coming edge
            m_rv0 = (winner == 0);
            m_rv1 = (winner == 1);
            if (winner == 0) m_rd0 = e_we ? 32'd0 : ref_mem[e_addr];
            if (winner == 1) m_rd1 = e_we ? 32'd0 : ref_mem[e_addr];
            if (winner >= 0 && e_we) ref_mem[e_addr] = e_din;
            if (req1_valid && winner != 1) m_lost = (m_lost + 1 > MAX_WAIT) ? MAX_WAIT : m_lost + 1;
            else m_lost = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] s);
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_strb = s;
   endtask
   task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] s);
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_strb = s;
   endtask
   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      bit acc0, acc1;
      clk = 0; rst = 1;
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         dmem[i]    = 32'hC0DE0000 + i;
         ref_mem[i] = 32'hC0DE0000 + i;
      end
      model_on = 1;

      @(negedge clk);
      check("lit_reset_rsp0_v", rsp0_valid, 0);
      check("lit_reset_rsp0_d", rsp0_rdata, 0);
      step(); rst = 0;

      // port 0 write then read of the same word
      step(); drive0(1, 1, 3, 32'hAABBCCDD, 3'b010);
      @(negedge clk);
      check("lit_wr_ready0", req0_ready, 1);
      check("lit_wr_mem_we", mem_we0, 1);
      check("lit_wr_strb", mem_wr_strb, 3'b010);
      step(); drive0(1, 0, 3, 0, 0);
      @(negedge clk);
      check("lit_wr_rsp_v", rsp0_valid, 1);
      check("lit_wr_rsp_d", rsp0_rdata, 0);
      step(); drive0(0, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_rd_rsp_v", rsp0_valid, 1);
      check("lit_rd_rsp_d", rsp0_rdata, 32'hAABBCCDD);

      // starvation bound
      step(); drive0(1, 0, 1, 0, 0); drive1(1, 0, 4, 0, 0);
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         check("lit_starve_ready1", req1_ready, c == 4);
         check("lit_starve_ready0", req0_ready, c != 4);
         step();
      end
      drive1(0, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_starve_wait", dut.wait_cnt_q, 0);
      check("lit_starve_rsp1_v", rsp1_valid, 1);
      check("lit_starve_rsp1_d", rsp1_rdata, 32'hC0DE0004);
      step(); drive0(0, 0, 0, 0, 0);

      // port 1 alone
      drive1(1, 0, 5, 0, 0);
      @(negedge clk);
      check("lit_p1_ready", req1_ready, 1);
      step(); drive1(0, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_p1_rsp_v", rsp1_valid, 1);
      check("lit_p1_rsp_d", rsp1_rdata, 32'hC0DE0005);

      // cross-port write then read
      step(); drive1(1, 1, 2, 32'h12345678, 3'b010);
      @(negedge clk);
      check("lit_x_ready1", req1_ready, 1);
      step(); drive1(0, 0, 0, 0, 0); drive0(1, 0, 2, 0, 0);
      step(); drive0(0, 0, 0, 0, 0);
      @(negedge clk);
      check("lit_x_rsp0_d", rsp0_rdata, 32'h12345678);

      // reset mid-operation with rsp0_valid=1 and wait_cnt=3
      step(); drive0(1, 1, 6, 32'h66666666, 3'b010); drive1(1, 0, 7, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      check("lit_pre_rst_wait", dut.wait_cnt_q, 3);
      check("lit_pre_rst_rsp0_v", rsp0_valid, 1);
      #1 rst = 1;
      #1;
      check("lit_rst_rsp0_v", rsp0_valid, 0);
      check("lit_rst_wait", dut.wait_cnt_q, 0);
      check("lit_rst_mem_we", mem_we0, 0);
      check("lit_rst_ready0", req0_ready, 0);
      step(); rst = 0;
      @(negedge clk);
      check("lit_post_rst_ready0", req0_ready, 1);
      check("lit_post_rst_mem_we", mem_we0, 1);
      step(); drive0(0, 0, 0, 0, 0);

      // randomized traffic with occasional resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         acc0 = req0_ready;
         acc1 = req1_ready;
         step();
         if (rst) rst = 0;
         else if ($urandom_range(0, 149) == 0) rst = 1;
         if (!req0_valid || acc0)
            drive0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, 3'($urandom_range(0, 7)));
         if (!req1_valid || acc1)
            drive1($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, 3'($urandom_range(0, 7)));
      end

      rst = 0;
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
